// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: MD op encodings, R-type funct codes and
// state/helper decode used by md_unit, EX control and hazard control alike.
package md_unit_pkg;

   typedef enum logic [2:0] {
      MD_OP_MULT  = 3'd0,
      MD_OP_MULTU = 3'd1,
      MD_OP_DIV   = 3'd2,
      MD_OP_DIVU  = 3'd3,
      MD_OP_MTHI  = 3'd4,
      MD_OP_MTLO  = 3'd5,
      MD_OP_RSV6  = 3'd6,
      MD_OP_RSV7  = 3'd7
   } md_op_e;

   // R-type funct field values for the HI/LO instruction group
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
             (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_core.sv
// Combinational signed/unsigned multiply and divide producing {hi, lo},
// including the divide-by-zero and most-negative/-1 rules.
module md_unit_core
   import md_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int W2 = 2 * WIDTH;

   logic signed [W2-1:0] prod_s;
   logic [W2-1:0]        prod_u;
   logic                 div_signed;
   logic                 a_neg;
   logic                 b_neg;
   logic [WIDTH-1:0]     dvd;
   logic [WIDTH-1:0]     dvs;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;

   assign prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) *
                   $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
   assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

   // Signed divide runs on magnitudes. The most-negative/-1 case falls out
   // naturally: |a| = 2^(W-1) fits unsigned, and negating it yields a again.
   assign div_signed = (op_i == MD_OP_DIV);
   assign a_neg      = div_signed & a_i[WIDTH-1];
   assign b_neg      = div_signed & b_i[WIDTH-1];
   assign dvd        = a_neg ? -a_i : a_i;
   assign dvs        = b_neg ? -b_i : b_i;

   always_comb begin
      quo = '0;
      rem = '0;
      if (dvs != '0) begin
         quo = dvd / dvs;
         rem = dvd % dvs;
      end
   end

   assign quo_fix = (a_neg ^ b_neg) ? -quo : quo;
   assign rem_fix = a_neg ? -rem : rem;

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      case (op_i)
         MD_OP_MULT: begin
            hi_o = prod_s[W2-1:WIDTH];
            lo_o = prod_s[WIDTH-1:0];
         end
         MD_OP_MULTU: begin
            hi_o = prod_u[W2-1:WIDTH];
            lo_o = prod_u[WIDTH-1:0];
         end
         MD_OP_DIV, MD_OP_DIVU: begin
            if (b_i == '0) begin
               hi_o = a_i;
               lo_o = '1;
            end else begin
               hi_o = rem_fix;
               lo_o = quo_fix;
            end
         end
         default: begin
            hi_o = '0;
            lo_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at issue, held in pending registers and committed when the latency counter expires.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state | meaning
   // IDLE  | ready; mthi/mtlo write directly, mult/div load pending result
   // BUSY  | counting down; commits pending result at zero unless cancelled

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
   logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] core_hi;
   logic [WIDTH-1:0] core_lo;
   logic             req_ok;
   logic             load;
   logic             commit;

   md_unit_core #(.WIDTH(WIDTH)) u_core (
      .op_i (op),
      .a_i  (a),
      .b_i  (b),
      .hi_o (core_hi),
      .lo_o (core_lo)
   );

   // Cancel outranks both a same-cycle issue and a same-cycle commit
   assign req_ok = (state_q == ST_IDLE) && start && !cancel;
   assign load   = req_ok && md_is_arith(op);
   assign commit = (state_q == ST_BUSY) && !cancel && (cnt_q == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (load) state_d = ST_BUSY;
         ST_BUSY: if (cancel || (cnt_q == '0)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == ST_BUSY);
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (load) begin
         cnt_d     = md_is_div(op) ? DIV_LOAD : MULT_LOAD;
         pend_hi_d = core_hi;
         pend_lo_d = core_lo;
      end else if (state_q == ST_BUSY) begin
         cnt_d = (cancel || (cnt_q == '0)) ? '0 : cnt_q - 1'b1;
      end
      if (commit) begin
         hi_d = pend_hi_q;
         lo_d = pend_lo_q;
      end
      if (req_ok && (op == MD_OP_MTHI)) hi_d = a;
      if (req_ok && (op == MD_OP_MTLO)) lo_d = a;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops checked
// against an arithmetic reference model of HI/LO and busy duration.
module tb_md_unit;

   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cancel = 1'b0;
   logic          busy;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // Hazard control must never issue while the unit is busy
   always @(posedge clk) begin
      if (reset && start && busy && !cancel)
         assert (1'b0) else $error("start issued while busy");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: architectural effect of one accepted op on HI/LO
   task automatic ref_apply(input logic [2:0] rop, input logic [31:0] ra, input logic [31:0] rb);
      int              sa;
      int              sb;
      longint          p;
      longint unsigned pu;
      sa = ra;
      sb = rb;
      case (rop)
         3'd0: begin
            p = longint'(sa) * longint'(sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         3'd1: begin
            pu = {32'b0, ra} * {32'b0, rb};
            m_hi = pu[63:32];
            m_lo = pu[31:0];
         end
         3'd2: begin
            if (rb == 0) begin
               m_hi = ra; m_lo = 32'hFFFF_FFFF;
            end else if (ra == 32'h8000_0000 && sb == -1) begin
               m_hi = 0; m_lo = ra;
            end else begin
               m_lo = sa / sb;
               m_hi = sa % sb;
            end
         end
         3'd3: begin
            if (rb == 0) begin
               m_hi = ra; m_lo = 32'hFFFF_FFFF;
            end else begin
               m_lo = ra / rb;
               m_hi = ra % rb;
            end
         end
         3'd4: m_hi = ra;
         3'd5: m_lo = ra;
         default: ;
      endcase
   endtask

   function automatic int exp_cycles(input logic [2:0] rop);
      if (rop <= 3'd1) return MC;
      if (rop <= 3'd3) return DC;
      return 0;
   endfunction

   // Issue one op, measure busy length, then check committed HI/LO
   task automatic do_op(input string tag, input logic [2:0] rop,
                        input logic [31:0] ra, input logic [31:0] rb);
      logic [31:0] old_h;
      int          n_exp;
      int          cyc;
      old_h = m_hi;
      n_exp = exp_cycles(rop);
      ref_apply(rop, ra, rb);
      @(negedge clk);
      start = 1'b1; op = rop; a = ra; b = rb;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom;
      if (n_exp > 0) chk({tag, "_hold_hi"}, 64'(hi), 64'(old_h));
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_busy_len"}, 64'(cyc), 64'(n_exp));
      chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
      chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          cyc;

      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
      chk("mult_neg_hi_c", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_neg_lo_c", 64'(lo), 64'hFFFF_FFFA);
      do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
      chk("multu_hi_c", 64'(hi), 64'h1);
      chk("multu_lo_c", 64'(lo), 64'hFFFF_FFFE);
      do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg_lo_c", 64'(lo), 64'hFFFF_FFFD);
      chk("div_neg_hi_c", 64'(hi), 64'hFFFF_FFFF);
      do_op("divu_zero", 3'd3, 32'd10, 32'd0);
      chk("divu_zero_lo_c", 64'(lo), 64'hFFFF_FFFF);
      chk("divu_zero_hi_c", 64'(hi), 64'hA);
      do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_lo_c", 64'(lo), 64'h8000_0000);
      chk("div_ovf_hi_c", 64'(hi), 64'h0);

      // mthi then mtlo back to back
      @(negedge clk);
      start = 1'b1; op = 3'd4; a = 32'h1234;
      @(negedge clk);
      chk("mthi_hi", 64'(hi), 64'h1234);
      chk("mthi_busy", 64'(busy), 64'd0);
      op = 3'd5; a = 32'h5678;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_lo", 64'(lo), 64'h5678);
      chk("mtlo_busy", 64'(busy), 64'd0);
      m_hi = 32'h1234; m_lo = 32'h5678;

      // Cancel in busy cycle 3: no commit, ever
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("cxl_busy3", 64'(busy), 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cxl_busy_off", 64'(busy), 64'd0);
      repeat (MC + 2) @(negedge clk);
      chk("cxl_hi", 64'(hi), 64'h1234);
      chk("cxl_lo", 64'(lo), 64'h5678);
      chk("cxl_busy_late", 64'(busy), 64'd0);

      // Cancel in IDLE suppresses a same-cycle mthi and mult
      start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hDEAD;
      @(negedge clk);
      chk("cxl_idle_mthi", 64'(hi), 64'h1234);
      op = 3'd0; a = 32'd7; b = 32'd7;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("cxl_idle_mult", 64'(busy), 64'd0);
      repeat (MC + 2) @(negedge clk);
      chk("cxl_idle_lo", 64'(lo), 64'h5678);

      // Asynchronous reset mid-divide
      @(negedge clk);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_hi", 64'(hi), 64'd0);
      chk("arst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi = 0; m_lo = 0;
      repeat (DC + 2) @(negedge clk);
      chk("arst_no_commit", 64'(lo), 64'd0);

      // Randomized ops with corner-biased operands
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
            4: rb = 32'($signed(-$urandom_range(1, 9)));
            default: ;
         endcase
         do_op("rand", rop, ra, rb);
      end

      cyc = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline; sits in EX beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from EX and holds busy for a configurable latency.
- Hazard control uses busy|start to stall any HI/LO-dependent instruction in D.
- Adds a cancel input so an in-flight operation can be squashed on pipeline flush.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu; must be >=1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >=1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request; qualifies op/a/b.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved (no-op).
- a  input  WIDTH  rs operand, forwarded.
- b  input  WIDTH  rt operand, forwarded.
- cancel  input  1  abort the in-flight operation; HI/LO keep their old values.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async):
  - busy=0, hi=0, lo=0, counter=0.
  - FSM enters IDLE and pending result registers clear.
  - Reset mid-operation discards the result.
- FSM states: IDLE, BUSY.
- IDLE, start=1, op in {0..3}:
  - Compute the result combinationally from a/b.
  - Latch it into pend_hi/pend_lo.
  - Load counter with N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from the next cycle.
- IDLE, start=1, op=4/5:
  - hi (resp. lo) <= a at this edge.
  - busy stays 0; no state change.
- IDLE, start=1, op=6/7: ignored.
- BUSY:
  - Counter decrements each cycle.
  - At counter==0 the edge commits hi<=pend_hi, lo<=pend_lo, busy<=0, FSM goes to IDLE.
- Latency:
  - Start accepted at edge t; busy high during cycles t+1 .. t+N.
  - New hi/lo visible in cycle t+N+1.
- start while BUSY (any op):
  - Ignored, no effect.
  - Hazard control must never issue this; the bench flags it as an assertion.
- cancel=1:
  - In BUSY: go to IDLE next edge, busy=0, no commit.
  - Cancel has priority over a same-cycle commit (counter==0).
  - In IDLE: suppresses a same-cycle start, including mthi/mtlo.
- Arithmetic, multiply:
  - mult: signed WIDTH×WIDTH -> 2·WIDTH; hi=upper half, lo=lower half.
  - multu: unsigned.
- Arithmetic, divide:
  - div: signed; quotient truncates toward zero into lo; remainder into hi, taking the sign of the dividend.
  - divu: unsigned.
- Divide by zero (b==0): lo = all ones, hi = a; full DIV_CYCLES latency still applies.
- Signed overflow (a = most negative, b = -1, op=div): lo=a, hi=0; no trap.
- hi/lo are registers only, with no combinational path from inputs; mfhi/mflo read them in EX via the existing forwarding muxes.

Decomposition:
- Shared package (mips_defs):
  - MD_OP_* encodings.
  - The mult/multu/div/divu/mfhi/mflo/mthi/mtlo funct constants, so EX_Control, Conflict_Control and md_unit decode identically.
- Optional sub-module md_core: pure combinational signed/unsigned mul/div producing {hi, lo}, including the zero/overflow rules.
- The FSM, counter and HI/LO registers stay in md_unit.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3 at t -> busy high t+1..t+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at t+6.
- multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), busy exactly 10 cycles.
- divu a=10, b=0 -> lo=0xFFFFFFFF, hi=0x0000000A; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x1234 then mtlo a=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 one edge after each, busy never asserts.
- Squash mid-operation:
  - Start mult (3×4) with hi/lo=0x1234/0x5678, then cancel=1 in busy cycle 3 -> busy=0 next cycle, hi/lo unchanged.
  - Separately, pull reset low asynchronously mid-div -> busy, hi and lo go to 0 immediately.
